alarm_trigger_ctrl: RTL
=======================

# alarm_trigger_ctrl

Alarm sequencing stage directly upstream of the blinking-bell overlay: compares the running clock time against the programmed alarm time and produces the `alarma_on` level that the overlay consumes to blink its image. It implements ring, stop, snooze and auto-timeout behaviour, all paced by the one-second tick from the real-time-clock path. It sits between the RTC/alarm-register block and the VGA overlay logic, in the single `clk` domain.

## Interface
- `RING_TIMEOUT`, 60: number of `tick_1s` pulses the alarm rings before self-clearing (1..511).
- `SNOOZE_SEC`, 300: number of `tick_1s` pulses spent in snooze before ringing again (1..511).
- `MAX_SNOOZE`, 3: number of snoozes accepted per alarm event (0..7).
- `clk`  in  1  system clock (pixel/system clock, same as overlay).
- `reset`  in  1  asynchronous, active-low reset.
- `tick_1s`  in  1  one-cycle pulse, once per second.
- `hora`  in  8  current hours, BCD.
- `minuto`  in  8  current minutes, BCD.
- `alarma_hora`  in  8  alarm hours, BCD.
- `alarma_minuto`  in  8  alarm minutes, BCD.
- `alarma_en`  in  1  alarm armed (level).
- `stop`  in  1  one-cycle pulse, user dismisses alarm.
- `snooze`  in  1  one-cycle pulse, user requests snooze.
- `alarma_on`  out  1  high while ringing; feeds the overlay.
- `snoozing`  out  1  high while in snooze.
- `snooze_cnt`  out  3  snoozes used in the current alarm event.

## Operation
- `match = alarma_en & (hora==alarma_hora) & (minuto==alarma_minuto)`; raw 8-bit compare, no BCD validation.
- `match_d` register holds previous `match`; trigger = `match & ~match_d`. Reset value of `match_d` is 1, so no trigger fires when reset releases inside a matching minute.
- States: IDLE, RINGING, SNOOZE.
- IDLE: trigger -> RINGING, `sec_cnt`<=0, `snooze_cnt`<=0.
- RINGING: on `tick_1s`, `sec_cnt`+1; if `sec_cnt==RING_TIMEOUT-1` on a tick -> IDLE. `stop` -> IDLE. `snooze` with `snooze_cnt<MAX_SNOOZE` -> SNOOZE, `sec_cnt`<=0, `snooze_cnt`+1; `snooze` when the limit is reached is ignored.
- SNOOZE: on `tick_1s`, `sec_cnt`+1; if `sec_cnt==SNOOZE_SEC-1` on a tick -> RINGING, `sec_cnt`<=0. `stop` -> IDLE.
- Any state: `alarma_en`=0 -> IDLE next edge, `sec_cnt`<=0.
- Priority in one cycle: `alarma_en` low > `stop` > `snooze` > tick expiry > tick count.
- Trigger in RINGING or SNOOZE is ignored. A new minute match after returning to IDLE re-triggers only on a fresh rising edge of `match`.
- `sec_cnt` is 9 bits. `snooze_cnt` saturates at `MAX_SNOOZE` and holds its value in IDLE until the next trigger.
- `alarma_on` = (state==RINGING). `snoozing` = (state==SNOOZE). Both decode directly from the state register, with no combinational input path.

## Timing
- Reset (asynchronous, `reset`=0): state IDLE, `sec_cnt`=0, `snooze_cnt`=0, `match_d`=1, `alarma_on`=0, `snoozing`=0.
- Trigger latency: `match` rises in cycle N; state and `alarma_on` change at the edge ending cycle N; `alarma_on` is high from cycle N+1.
- `stop`/`snooze`: one-cycle latency to output change.
- A `tick_1s` coincident with the entry edge into RINGING/SNOOZE is not counted. Ringing lasts exactly `RING_TIMEOUT` subsequent ticks, and snooze lasts exactly `SNOOZE_SEC` subsequent ticks.
- Expiry tick and `stop` in the same cycle: -> IDLE. Expiry tick and `snooze` in the same RINGING cycle: snooze wins if allowed, else -> IDLE.
- Reset asserted mid-ring: outputs drop asynchronously, and no re-trigger occurs in the same minute after release.

## Test plan
- Sim with `RING_TIMEOUT`=4, `SNOOZE_SEC`=3, `MAX_SNOOZE`=2. Set alarm 07:30, drive time 07:29 -> 07:30 -> `alarma_on`=1 one cycle later. After 4 ticks -> `alarma_on`=0, and it stays 0 for the rest of 07:30.
- Ringing, pulse `snooze` -> `snoozing`=1, `snooze_cnt`=1. After 3 ticks -> `alarma_on`=1. Snooze again -> `snooze_cnt`=2. A third snooze is ignored, and the alarm times out after 4 ticks.
- Ringing, `stop` and `snooze` in the same cycle -> IDLE, `snoozing`=0, `snooze_cnt`=0.
- Ringing, drop `alarma_en` -> IDLE next edge. Re-raise `alarma_en` within 07:30 -> re-triggers, because `match` rises again.
- Reset released while time=07:30=alarm -> no ring. Advance to 07:31, set alarm 07:31 -> no ring, because `match` stays high. Go 07:31->07:32 with alarm 07:32 -> ring.
- Tick on the same cycle as the trigger -> ring still lasts 4 further ticks. Tick on the same cycle as `snooze` -> snooze lasts 3 further ticks.

Source files
------------

// File: rtl/alarm_trigger_ctrl.sv
// Alarm sequencer feeding the blinking-bell overlay: detects the alarm minute,
// then rings, snoozes and times out, all paced by the one-second tick.
module alarm_trigger_ctrl #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SEC   = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [7:0] hora,
    input  logic [7:0] minuto,
    input  logic [7:0] alarma_hora,
    input  logic [7:0] alarma_minuto,
    input  logic       alarma_en,
    input  logic       stop,
    input  logic       snooze,
    output logic       alarma_on,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RINGING = 2'd1,
        S_SNOOZE  = 2'd2
    } state_t;

    localparam logic [8:0] RING_LAST   = 9'(RING_TIMEOUT - 1);
    localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
    localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [8:0] r_sec_cnt;
    logic [8:0] w_sec_cnt_nxt;
    logic [2:0] r_snooze_cnt;
    logic [2:0] w_snooze_cnt_nxt;
    logic       r_match_d;
    logic       w_match;
    logic       w_trigger;

    assign w_match   = alarma_en && (hora == alarma_hora) && (minuto == alarma_minuto);
    // match_d resets high so releasing reset inside the alarm minute cannot ring.
    assign w_trigger = w_match && !r_match_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sec_cnt    <= 9'd0;
            r_snooze_cnt <= 3'd0;
            r_match_d    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sec_cnt    <= w_sec_cnt_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
            r_match_d    <= w_match;
        end
    end

    // Branch order encodes the priority: disable > stop > snooze > expiry > count.
    always_comb begin
        w_state_nxt      = r_state;
        w_sec_cnt_nxt    = r_sec_cnt;
        w_snooze_cnt_nxt = r_snooze_cnt;
        if (!alarma_en) begin
            w_state_nxt   = S_IDLE;
            w_sec_cnt_nxt = 9'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        w_state_nxt      = S_RINGING;
                        w_sec_cnt_nxt    = 9'd0;
                        w_snooze_cnt_nxt = 3'd0;
                    end
                end
                S_RINGING: begin
                    if (stop) begin
                        w_state_nxt   = S_IDLE;
                        w_sec_cnt_nxt = 9'd0;
                    end else if (snooze && (r_snooze_cnt < SNOOZE_MAX)) begin
                        w_state_nxt      = S_SNOOZE;
                        w_sec_cnt_nxt    = 9'd0;
                        w_snooze_cnt_nxt = r_snooze_cnt + 3'd1;
                    end else if (tick_1s) begin
                        if (r_sec_cnt == RING_LAST) begin
                            w_state_nxt   = S_IDLE;
                            w_sec_cnt_nxt = 9'd0;
                        end else begin
                            w_sec_cnt_nxt = r_sec_cnt + 9'd1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (stop) begin
                        w_state_nxt   = S_IDLE;
                        w_sec_cnt_nxt = 9'd0;
                    end else if (tick_1s) begin
                        if (r_sec_cnt == SNOOZE_LAST) begin
                            w_state_nxt   = S_RINGING;
                            w_sec_cnt_nxt = 9'd0;
                        end else begin
                            w_sec_cnt_nxt = r_sec_cnt + 9'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_sec_cnt_nxt = 9'd0;
                end
            endcase
        end
    end

    assign alarma_on  = (r_state == S_RINGING);
    assign snoozing   = (r_state == S_SNOOZE);
    assign snooze_cnt = r_snooze_cnt;

endmodule
